// File: rtl/timer_mmss_countdown_pkg.sv
// Shared types for the MM:SS countdown: state encoding and BCD digit limits.
// No ports; imported by the interface, the digit cell and the top.
package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [3:0] BCD_MAX   = 4'd9;
  localparam logic [3:0] SEC_T_MAX = 4'd5;

endpackage

// File: rtl/timer_mmss_countdown_if.sv
// Command/load/status bundle between keypad logic and the countdown timer.
// master: keypad/control side; slave: the timer.
interface timer_mmss_countdown_if;

  logic       load;
  logic [3:0] ld_min_t;
  logic [3:0] ld_min_u;
  logic [3:0] ld_sec_t;
  logic [3:0] ld_sec_u;
  logic       start;
  logic       pause;
  logic       clear;
  logic       door_open;

  logic [3:0] min_t;
  logic [3:0] min_u;
  logic [3:0] sec_t;
  logic [3:0] sec_u;
  logic       running;
  logic       done;
  logic [1:0] state;

  modport master (
    output load, ld_min_t, ld_min_u,
    output ld_sec_t, ld_sec_u,
    output start, pause, clear, door_open,
    input  min_t, min_u, sec_t, sec_u,
    input  running, done, state
  );

  modport slave (
    input  load, ld_min_t, ld_min_u,
    input  ld_sec_t, ld_sec_u,
    input  start, pause, clear, door_open,
    output min_t, min_u, sec_t, sec_u,
    output running, done, state
  );

endinterface

// File: rtl/timer_mmss_countdown_digit.sv
// One BCD down-counting digit, wraps 0 -> MAX and borrows from the next digit.
// Ports: clk, rst, en_i, load_i, din_i (clamped to MAX), borrow_i -> q_o, borrow_o.
module bcd_down_digit #(
  parameter logic [3:0] MAX = 4'd9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_i,
  input  logic       load_i,
  input  logic [3:0] din_i,
  input  logic       borrow_i,
  output logic [3:0] q_o,
  output logic       borrow_o
);

  logic [3:0] q_q, q_d;
  logic       dec;

  assign dec      = en_i & borrow_i;
  assign borrow_o = dec & (q_q == 4'd0);
  assign q_o      = q_q;

  always_comb begin
    q_d = q_q;
    if (load_i) begin
      q_d = (din_i > MAX) ? MAX : din_i;
    end else if (dec) begin
      q_d = (q_q == 4'd0) ? MAX : q_q - 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q_q <= 4'd0;
    else     q_q <= q_d;
  end

endmodule

// File: rtl/timer_mmss_countdown.sv
// MM:SS cook-time countdown: prescaled 1 s tick, BCD digit chain, IDLE/RUN/PAUSE/DONE FSM.
// Ports: clk, rst (async, active high), bus (slave: commands in, digits/status out).
module timer_mmss_countdown
  import timer_pkg::*;
#(
  parameter int unsigned TICK_DIV = 50_000_000
) (
  input logic                   clk,
  input logic                   rst,
  timer_mmss_countdown_if.slave bus
);

  localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(TICK_DIV - 1);

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          done_q, done_d;

  logic          dig_ld;
  logic          dec;
  logic          hold;
  logic          tick;
  logic          is_zero;
  logic          is_one;
  logic [15:0]   cnt;
  logic [3:0]    din_mt, din_mu, din_st, din_su;
  logic          b_su, b_st, b_mu, b_mt;

  assign cnt     = {bus.min_t, bus.min_u, bus.sec_t, bus.sec_u};
  assign is_zero = (cnt == 16'h0000);
  assign is_one  = (cnt == 16'h0001);
  assign hold    = bus.pause | bus.door_open;
  assign tick    = (presc_q == PS_LAST);

  // clear shares the load path with all-zero data
  assign din_mt = bus.clear ? 4'd0 : bus.ld_min_t;
  assign din_mu = bus.clear ? 4'd0 : bus.ld_min_u;
  assign din_st = bus.clear ? 4'd0 : bus.ld_sec_t;
  assign din_su = bus.clear ? 4'd0 : bus.ld_sec_u;

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    done_d  = 1'b0;
    dig_ld  = 1'b0;
    dec     = 1'b0;
    if (bus.clear) begin
      state_d = ST_IDLE;
      presc_d = '0;
      dig_ld  = 1'b1;
    end else if (bus.load && state_q != ST_RUN) begin
      state_d = ST_IDLE;
      presc_d = '0;
      dig_ld  = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (bus.start && !hold && !is_zero) begin
            state_d = ST_RUN;
            presc_d = '0;
          end
        end
        ST_PAUSE: begin
          if (bus.start && !hold && !is_zero)
            state_d = ST_RUN;
        end
        ST_RUN: begin
          if (hold) begin
            state_d = ST_PAUSE;
          end else begin
            presc_d = tick ? '0 : presc_q + 1'b1;
            if (tick) begin
              dec = 1'b1;
              // 00:01 is the last value that may be decremented
              if (is_one) begin
                state_d = ST_DONE;
                done_d  = 1'b1;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      presc_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      done_q  <= done_d;
    end
  end

  bcd_down_digit #(.MAX(BCD_MAX)) u_sec_u (
    .clk(clk), .rst(rst), .en_i(dec), .load_i(dig_ld),
    .din_i(din_su), .borrow_i(1'b1),
    .q_o(bus.sec_u), .borrow_o(b_su)
  );

  bcd_down_digit #(.MAX(SEC_T_MAX)) u_sec_t (
    .clk(clk), .rst(rst), .en_i(dec), .load_i(dig_ld),
    .din_i(din_st), .borrow_i(b_su),
    .q_o(bus.sec_t), .borrow_o(b_st)
  );

  bcd_down_digit #(.MAX(BCD_MAX)) u_min_u (
    .clk(clk), .rst(rst), .en_i(dec), .load_i(dig_ld),
    .din_i(din_mu), .borrow_i(b_st),
    .q_o(bus.min_u), .borrow_o(b_mu)
  );

  bcd_down_digit #(.MAX(BCD_MAX)) u_min_t (
    .clk(clk), .rst(rst), .en_i(dec), .load_i(dig_ld),
    .din_i(din_mt), .borrow_i(b_mu),
    .q_o(bus.min_t), .borrow_o(b_mt)
  );

  assign bus.state   = state_q;
  assign bus.running = (state_q == ST_RUN);
  assign bus.done    = done_q;

endmodule
